// File: rtl/dcache_port_sched.sv
// Serialises the two mem-stage slots onto the single dcache port, one transaction outstanding at a time.
// Optional performance counters are built only when DCACHE_SCHED_PERF_EN is defined.
module dcache_port_sched #(
   parameter int ISSUE_WIDTH = 2,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              mem_valid_i,
   input  logic [ISSUE_WIDTH-1:0]            slot_mem_i,
   input  logic [ISSUE_WIDTH-1:0]            slot_excp_i,
   input  logic [ISSUE_WIDTH-1:0]            slot_we_i,
   input  logic [ISSUE_WIDTH*ADDR_W-1:0]     slot_addr_i,
   input  logic [ISSUE_WIDTH*DATA_W-1:0]     slot_wdata_i,
   input  logic [ISSUE_WIDTH*(DATA_W/8)-1:0] slot_wstrb_i,
   input  logic                              stall_i,
   input  logic                              flush_i,
   output logic                              dc_req_o,
   output logic                              dc_we_o,
   output logic [ADDR_W-1:0]                 dc_addr_o,
   output logic [DATA_W-1:0]                 dc_wdata_o,
   output logic [DATA_W/8-1:0]               dc_wstrb_o,
   input  logic                              dc_addr_ok_i,
   input  logic                              dc_data_ok_i,
   input  logic [DATA_W-1:0]                 dc_rdata_i,
   output logic [ISSUE_WIDTH*DATA_W-1:0]     slot_rdata_o,
   output logic [ISSUE_WIDTH-1:0]            slot_done_o,
   output logic                              pause_mem_o,
   output logic [31:0]                       perf_req_cnt_o,
   output logic [31:0]                       perf_stall_cnt_o
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ0  = 3'd1,
      WAIT0 = 3'd2,
      REQ1  = 3'd3,
      WAIT1 = 3'd4,
      DONE  = 3'd5,
      DRAIN = 3'd6
   } state_t;

   state_t                                  state_q, state_d;
   logic [ISSUE_WIDTH-1:0]                  we_q, we_d;
   logic [ISSUE_WIDTH-1:0][ADDR_W-1:0]      addr_q, addr_d;
   logic [ISSUE_WIDTH-1:0][DATA_W-1:0]      wdata_q, wdata_d;
   logic [ISSUE_WIDTH-1:0][DATA_W/8-1:0]    wstrb_q, wstrb_d;
   logic [ISSUE_WIDTH-1:0][DATA_W-1:0]      rdata_q, rdata_d;
   logic [ISSUE_WIDTH-1:0]                  done_q, done_d;
   logic                                    need1_q, need1_d;
   logic [ISSUE_WIDTH-1:0]                  need;
   logic                                    cur_slot;

   // A slot-0 exception also kills slot 1, which is younger in program order.
   assign need[0] = mem_valid_i & slot_mem_i[0] & ~slot_excp_i[0];
   assign need[1] = mem_valid_i & slot_mem_i[1] & ~slot_excp_i[1] & ~slot_excp_i[0];

   assign cur_slot = (state_q == REQ1);

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
      rdata_d = rdata_q;
      done_d  = done_q;
      need1_d = need1_q;
      case (state_q)
         IDLE: begin
            if (!flush_i && (|need)) begin
               we_d    = slot_we_i;
               addr_d  = slot_addr_i;
               wdata_d = slot_wdata_i;
               wstrb_d = slot_wstrb_i;
               need1_d = need[1];
               rdata_d = '0;
               done_d  = '0;
               state_d = need[0] ? REQ0 : REQ1;
            end
         end
         REQ0, REQ1: begin
            // Once the dcache has accepted, its response must be drained even on flush.
            if (dc_addr_ok_i) begin
               if (flush_i) begin
                  state_d = DRAIN;
                  rdata_d = '0;
                  done_d  = '0;
               end else begin
                  state_d = (state_q == REQ0) ? WAIT0 : WAIT1;
               end
            end else if (flush_i) begin
               state_d = IDLE;
               rdata_d = '0;
               done_d  = '0;
            end
         end
         WAIT0: begin
            if (dc_data_ok_i) begin
               if (flush_i) begin
                  state_d = IDLE;
                  rdata_d = '0;
                  done_d  = '0;
               end else begin
                  if (!we_q[0]) rdata_d[0] = dc_rdata_i;
                  done_d[0] = 1'b1;
                  state_d   = need1_q ? REQ1 : DONE;
               end
            end else if (flush_i) begin
               state_d = DRAIN;
               rdata_d = '0;
               done_d  = '0;
            end
         end
         WAIT1: begin
            if (dc_data_ok_i) begin
               if (flush_i) begin
                  state_d = IDLE;
                  rdata_d = '0;
                  done_d  = '0;
               end else begin
                  if (!we_q[1]) rdata_d[1] = dc_rdata_i;
                  done_d[1] = 1'b1;
                  state_d   = DONE;
               end
            end else if (flush_i) begin
               state_d = DRAIN;
               rdata_d = '0;
               done_d  = '0;
            end
         end
         DONE: begin
            if (flush_i) begin
               state_d = IDLE;
               rdata_d = '0;
               done_d  = '0;
            end else if (!stall_i) begin
               state_d = IDLE;
               done_d  = '0;
            end
         end
         DRAIN: begin
            if (dc_data_ok_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         we_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         rdata_q <= '0;
         done_q  <= '0;
         need1_q <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wstrb_q <= wstrb_d;
         rdata_q <= rdata_d;
         done_q  <= done_d;
         need1_q <= need1_d;
      end
   end

   // Payload is forced to zero whenever no request is presented.
   always_comb begin
      dc_req_o   = (state_q == REQ0) || (state_q == REQ1);
      dc_we_o    = 1'b0;
      dc_addr_o  = '0;
      dc_wdata_o = '0;
      dc_wstrb_o = '0;
      if (dc_req_o) begin
         dc_we_o    = we_q[cur_slot];
         dc_addr_o  = addr_q[cur_slot];
         dc_wdata_o = wdata_q[cur_slot];
         dc_wstrb_o = wstrb_q[cur_slot];
      end
      pause_mem_o = ((state_q == IDLE) && (|need)) ||
                    (state_q == REQ0) || (state_q == WAIT0) ||
                    (state_q == REQ1) || (state_q == WAIT1) ||
                    (state_q == DRAIN);
   end

   assign slot_rdata_o = rdata_q;
   assign slot_done_o  = done_q;

`ifdef DCACHE_SCHED_PERF_EN
   logic [31:0] req_cnt_q, req_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      req_cnt_d   = req_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (dc_req_o && dc_addr_ok_i) req_cnt_d = req_cnt_q + 32'd1;
      if (pause_mem_o) stall_cnt_d = stall_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_cnt_q   <= '0;
         stall_cnt_q <= '0;
      end else begin
         req_cnt_q   <= req_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign perf_req_cnt_o   = req_cnt_q;
   assign perf_stall_cnt_o = stall_cnt_q;
`else
   assign perf_req_cnt_o   = '0;
   assign perf_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_dcache_port_sched.sv
// Directed testbench for dcache_port_sched: single/dual access, exceptions, backpressure, flush/drain, perf counters.
module tb_dcache_port_sched;

   logic        clk;
   logic        rst_n;
   logic        mem_valid;
   logic [1:0]  slot_mem;
   logic [1:0]  slot_excp;
   logic [1:0]  slot_we;
   logic [63:0] slot_addr;
   logic [63:0] slot_wdata;
   logic [7:0]  slot_wstrb;
   logic        stall;
   logic        flush;
   logic        dc_req;
   logic        dc_we;
   logic [31:0] dc_addr;
   logic [31:0] dc_wdata;
   logic [3:0]  dc_wstrb;
   logic        dc_addr_ok;
   logic        dc_data_ok;
   logic [31:0] dc_rdata;
   logic [63:0] slot_rdata;
   logic [1:0]  slot_done;
   logic        pause_mem;
   logic [31:0] perf_req_cnt;
   logic [31:0] perf_stall_cnt;

   int checkCount;
   int passCount;
   int pauseCycles;

   dcache_port_sched dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .mem_valid_i      (mem_valid),
      .slot_mem_i       (slot_mem),
      .slot_excp_i      (slot_excp),
      .slot_we_i        (slot_we),
      .slot_addr_i      (slot_addr),
      .slot_wdata_i     (slot_wdata),
      .slot_wstrb_i     (slot_wstrb),
      .stall_i          (stall),
      .flush_i          (flush),
      .dc_req_o         (dc_req),
      .dc_we_o          (dc_we),
      .dc_addr_o        (dc_addr),
      .dc_wdata_o       (dc_wdata),
      .dc_wstrb_o       (dc_wstrb),
      .dc_addr_ok_i     (dc_addr_ok),
      .dc_data_ok_i     (dc_data_ok),
      .dc_rdata_i       (dc_rdata),
      .slot_rdata_o     (slot_rdata),
      .slot_done_o      (slot_done),
      .pause_mem_o      (pause_mem),
      .perf_req_cnt_o   (perf_req_cnt),
      .perf_stall_cnt_o (perf_stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compares one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checkCount++;
      if (obs === exp) passCount++;
      else $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
   endtask

   task automatic applyStimulus(input logic valid, input logic [1:0] mem, input logic [1:0] excp,
                                input logic [1:0] we, input logic [31:0] a0, input logic [31:0] a1,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [3:0] s0, input logic [3:0] s1);
      mem_valid  = valid;
      slot_mem   = mem;
      slot_excp  = excp;
      slot_we    = we;
      slot_addr  = {a1, a0};
      slot_wdata = {d1, d0};
      slot_wstrb = {s1, s0};
   endtask

   task automatic clearStimulus();
      applyStimulus(1'b0, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0);
   endtask

   // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checkCount = 0;
      passCount  = 0;
      rst_n      = 1'b0;
      stall      = 1'b0;
      flush      = 1'b0;
      dc_addr_ok = 1'b0;
      dc_data_ok = 1'b0;
      dc_rdata   = 32'h0;
      clearStimulus();
      #12;
      checkOutput("rst_req", {63'h0, dc_req}, 64'h0);
      checkOutput("rst_pause", {63'h0, pause_mem}, 64'h0);
      checkOutput("rst_done", {62'h0, slot_done}, 64'h0);
      checkOutput("rst_rdata", slot_rdata, 64'h0);
      checkOutput("rst_perf", {perf_req_cnt, perf_stall_cnt}, 64'h0);
      rst_n = 1'b1;

      // Single load from slot 0.
      nextCycle();
      pauseCycles = 0;
      applyStimulus(1'b1, 2'b01, 2'b00, 2'b00, 32'h1000, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0);
      #1;
      checkOutput("t1_c0_pause", {63'h0, pause_mem}, 64'h1);
      checkOutput("t1_c0_req", {63'h0, dc_req}, 64'h0);
      pauseCycles += int'(pause_mem);
      nextCycle();
      dc_addr_ok = 1'b1;
      #1;
      checkOutput("t1_req", {63'h0, dc_req}, 64'h1);
      checkOutput("t1_addr", {32'h0, dc_addr}, 64'h1000);
      checkOutput("t1_we", {63'h0, dc_we}, 64'h0);
      pauseCycles += int'(pause_mem);
      nextCycle();
      dc_addr_ok = 1'b0;
      dc_data_ok = 1'b1;
      dc_rdata   = 32'hDEADBEEF;
      #1;
      checkOutput("t1_wait_req", {63'h0, dc_req}, 64'h0);
      pauseCycles += int'(pause_mem);
      nextCycle();
      dc_data_ok = 1'b0;
      clearStimulus();
      #1;
      pauseCycles += int'(pause_mem);
      checkOutput("t1_done", {62'h0, slot_done}, 64'h1);
      checkOutput("t1_rdata0", {32'h0, slot_rdata[31:0]}, 64'hDEADBEEF);
      checkOutput("t1_pause_cycles", 64'(pauseCycles), 64'd3);
      nextCycle();
      checkOutput("t1_idle_done", {62'h0, slot_done}, 64'h0);

      // Store then load; counters restarted to observe this transaction alone.
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      nextCycle();
      pauseCycles = 0;
      applyStimulus(1'b1, 2'b11, 2'b00, 2'b01, 32'h2000, 32'h2004, 32'h11223344, 32'h0, 4'b0011, 4'h0);
      #1;
      pauseCycles += int'(pause_mem);
      nextCycle();
      dc_addr_ok = 1'b1;
      #1;
      checkOutput("t2_r0_req", {63'h0, dc_req}, 64'h1);
      checkOutput("t2_r0_we", {63'h0, dc_we}, 64'h1);
      checkOutput("t2_r0_addr", {32'h0, dc_addr}, 64'h2000);
      checkOutput("t2_r0_wdata", {32'h0, dc_wdata}, 64'h11223344);
      checkOutput("t2_r0_wstrb", {60'h0, dc_wstrb}, 64'h3);
      pauseCycles += int'(pause_mem);
      nextCycle();
      dc_addr_ok = 1'b0;
      dc_data_ok = 1'b1;
      dc_rdata   = 32'hAAAA5555;
      #1;
      pauseCycles += int'(pause_mem);
      nextCycle();
      dc_data_ok = 1'b0;
      dc_addr_ok = 1'b1;
      #1;
      checkOutput("t2_r1_req", {63'h0, dc_req}, 64'h1);
      checkOutput("t2_r1_we", {63'h0, dc_we}, 64'h0);
      checkOutput("t2_r1_addr", {32'h0, dc_addr}, 64'h2004);
      checkOutput("t2_r1_done", {62'h0, slot_done}, 64'h1);
      pauseCycles += int'(pause_mem);
      nextCycle();
      dc_addr_ok = 1'b0;
      dc_data_ok = 1'b1;
      dc_rdata   = 32'hCAFEF00D;
      #1;
      pauseCycles += int'(pause_mem);
      nextCycle();
      dc_data_ok = 1'b0;
      clearStimulus();
      #1;
      pauseCycles += int'(pause_mem);
      checkOutput("t2_done", {62'h0, slot_done}, 64'h3);
      checkOutput("t2_rdata", slot_rdata, 64'hCAFEF00D_00000000);
      checkOutput("t2_pause_cycles", 64'(pauseCycles), 64'd5);
`ifdef DCACHE_SCHED_PERF_EN
      checkOutput("t2_perf_req", {32'h0, perf_req_cnt}, 64'd2);
      checkOutput("t2_perf_stall", {32'h0, perf_stall_cnt}, 64'd5);
`else
      checkOutput("t2_perf_req", {32'h0, perf_req_cnt}, 64'd0);
      checkOutput("t2_perf_stall", {32'h0, perf_stall_cnt}, 64'd0);
`endif
      nextCycle();

      // Slot 0 exception suppresses both slots.
      applyStimulus(1'b1, 2'b11, 2'b01, 2'b00, 32'h3000, 32'h3004, 32'h0, 32'h0, 4'h0, 4'h0);
      #1;
      checkOutput("t3_pause", {63'h0, pause_mem}, 64'h0);
      nextCycle();
      checkOutput("t3_req", {63'h0, dc_req}, 64'h0);
      checkOutput("t3_pause_later", {63'h0, pause_mem}, 64'h0);
      clearStimulus();
      nextCycle();

      // Withheld addr_ok: request and payload held stable, then stall holds DONE.
      applyStimulus(1'b1, 2'b01, 2'b00, 2'b01, 32'h3000, 32'h0, 32'h55AA55AA, 32'h0, 4'hF, 4'h0);
      for (int i = 0; i < 4; i++) begin
         nextCycle();
         #1;
         checkOutput($sformatf("t4_hold%0d_req", i), {63'h0, dc_req}, 64'h1);
         checkOutput($sformatf("t4_hold%0d_payload", i), {dc_addr, dc_wdata}, 64'h00003000_55AA55AA);
         checkOutput($sformatf("t4_hold%0d_pause", i), {63'h0, pause_mem}, 64'h1);
      end
      nextCycle();
      dc_addr_ok = 1'b1;
      #1;
      checkOutput("t4_accept_req", {63'h0, dc_req}, 64'h1);
      nextCycle();
      dc_addr_ok = 1'b0;
      dc_data_ok = 1'b1;
      dc_rdata   = 32'h0BAD0BAD;
      nextCycle();
      dc_data_ok = 1'b0;
      stall      = 1'b1;
      clearStimulus();
      #1;
      checkOutput("t4_done", {62'h0, slot_done}, 64'h1);
      checkOutput("t4_store_rdata", slot_rdata, 64'h0);
      nextCycle();
      #1;
      checkOutput("t4_stall_done", {62'h0, slot_done}, 64'h1);
      checkOutput("t4_stall_pause", {63'h0, pause_mem}, 64'h0);
      stall = 1'b0;
      nextCycle();
      checkOutput("t4_released", {62'h0, slot_done}, 64'h0);

      // Flush in WAIT0 with late response: DRAIN swallows it, slot 1 never requested.
      applyStimulus(1'b1, 2'b11, 2'b00, 2'b00, 32'h4000, 32'h4004, 32'h0, 32'h0, 4'h0, 4'h0);
      nextCycle();
      dc_addr_ok = 1'b1;
      nextCycle();
      dc_addr_ok = 1'b0;
      flush      = 1'b1;
      #1;
      checkOutput("t5_wait_pause", {63'h0, pause_mem}, 64'h1);
      nextCycle();
      flush = 1'b0;
      clearStimulus();
      #1;
      checkOutput("t5_drain_pause", {63'h0, pause_mem}, 64'h1);
      checkOutput("t5_drain_req", {63'h0, dc_req}, 64'h0);
      nextCycle();
      dc_data_ok = 1'b1;
      dc_rdata   = 32'h12345678;
      #1;
      checkOutput("t5_drain2_req", {63'h0, dc_req}, 64'h0);
      nextCycle();
      dc_data_ok = 1'b0;
      #1;
      checkOutput("t5_done", {62'h0, slot_done}, 64'h0);
      checkOutput("t5_pause", {63'h0, pause_mem}, 64'h0);
      checkOutput("t5_rdata", slot_rdata, 64'h0);
      nextCycle();
      checkOutput("t5_no_req1", {63'h0, dc_req}, 64'h0);

      // Flush coinciding with data_ok in WAIT0 returns straight to IDLE.
      applyStimulus(1'b1, 2'b01, 2'b00, 2'b00, 32'h5000, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0);
      nextCycle();
      dc_addr_ok = 1'b1;
      nextCycle();
      dc_addr_ok = 1'b0;
      dc_data_ok = 1'b1;
      flush      = 1'b1;
      dc_rdata   = 32'h99999999;
      nextCycle();
      dc_data_ok = 1'b0;
      flush      = 1'b0;
      clearStimulus();
      #1;
      checkOutput("t6_pause", {63'h0, pause_mem}, 64'h0);
      checkOutput("t6_done", {62'h0, slot_done}, 64'h0);
      checkOutput("t6_rdata", slot_rdata, 64'h0);

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/dcache_port_sched.md
# dcache_port_sched

Sequences the memory operations of both issue slots in the mem stage onto the single dcache request port (`mem_dcache` handshake: req/addr_ok/data_ok). Slot 0 is served before slot 1 (program order), and only one dcache transaction is ever outstanding. The block returns each slot's raw 32-bit read word to the mem stage and drives the mem-stage pause to ctrl until every required access has completed. Flushes are handled safely by draining any transaction already accepted by the dcache.

## Interface
- `ISSUE_WIDTH`, 2: issue slots; fixed at 2.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width; `DATA_W/8` byte strobes.

Ports:
- `clk`  in  1  core clock; everything is sampled on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `mem_valid_i`  in  1  a new instruction pair is present in the mem stage.
- `slot_mem_i`  in  2  slot i needs a dcache access.
- `slot_excp_i`  in  2  slot i carries an exception; its access is suppressed.
- `slot_we_i`  in  2  slot i is a store (1) or a load (0).
- `slot_addr_i`  in  2×ADDR_W  word address per slot.
- `slot_wdata_i`  in  2×DATA_W  store data per slot.
- `slot_wstrb_i`  in  2×4  store byte strobes per slot.
- `stall_i`  in  1  downstream stall; the pipe does not advance this cycle.
- `flush_i`  in  1  pipeline flush.
- `dc_req_o`  out  1  dcache request valid.
- `dc_we_o`  out  1  dcache write enable.
- `dc_addr_o`  out  ADDR_W  dcache address.
- `dc_wdata_o`  out  DATA_W  dcache write data.
- `dc_wstrb_o`  out  4  dcache write strobes.
- `dc_addr_ok_i`  in  1  dcache accepted the request.
- `dc_data_ok_i`  in  1  response; returned for loads and stores.
- `dc_rdata_i`  in  DATA_W  load data, valid with `dc_data_ok_i`.
- `slot_rdata_o`  out  2×DATA_W  captured load word per slot.
- `slot_done_o`  out  2  slot i's access has completed.
- `pause_mem_o`  out  1  stall request to ctrl.
- `perf_req_cnt_o`  out  32  performance counter: accepted dcache requests.
- `perf_stall_cnt_o`  out  32  performance counter: cycles with `pause_mem_o` = 1.

## Operation
- Needed set: `need[i] = mem_valid_i & slot_mem_i[i] & ~slot_excp_i[i]`.
- If slot 0 has an exception, slot 1 is also suppressed (younger than the exception).
- FSM states: IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE, DRAIN.
- **IDLE**
  - If any `need` bit is set: latch all slot fields.
  - Go to REQ0 if `need[0]`, otherwise REQ1.
- **REQx**
  - `dc_req_o` = 1, driven from the latched fields of slot x.
  - On `dc_addr_ok_i`, go to WAITx.
- **WAITx**
  - On `dc_data_ok_i`: set `slot_rdata_o[x]` = `dc_rdata_i` (loads only) and `slot_done_o[x]` = 1.
  - Next state: from WAIT0, go to REQ1 if slot 1 is needed, otherwise DONE; from WAIT1, go to DONE.
- **DONE**
  - Results are held.
  - Stay while `stall_i` = 1.
  - Otherwise, next edge: go to IDLE and clear `slot_done_o`.
- **Flush** (`flush_i` = 1):
  - From IDLE, REQx (before `dc_addr_ok_i`), or DONE: go to IDLE and clear done/data.
  - From WAITx: go to DRAIN.
  - DRAIN discards the next `dc_data_ok_i`, then goes to IDLE.
  - While flush is pending, no new request is issued.
- `pause_mem_o` = (IDLE & any `need`) | state ∈ {REQ0, WAIT0, REQ1, WAIT1, DRAIN}. Deasserted in DONE.
- `dc_req_o` = 0 outside the REQ states. The `dc_*` payload outputs are 0 when `dc_req_o` = 0.

## Timing
- Reset: state IDLE; all outputs 0; counters 0.
- Minimum latency for a single access (`dc_addr_ok_i` in the request cycle, `dc_data_ok_i` one cycle later):
  - Cycle 0: latch.
  - Cycle 1: REQ.
  - Cycle 2: data.
  - Cycle 3: DONE with `pause_mem_o` = 0.
- Two accesses take 2 cycles more than a single access.
- `dc_data_ok_i` arriving in the same cycle as `flush_i` during WAITx counts as the drained response: go directly to IDLE.
- `rst_n` asserted mid-transaction: immediate IDLE. The dcache is reset by the same reset.
- `dc_data_ok_i` outside WAITx/DRAIN is ignored.

## Configuration
- `DCACHE_SCHED_PERF_EN`, when defined:
  - `perf_req_cnt_o` increments on each `dc_req_o & dc_addr_ok_i`.
  - `perf_stall_cnt_o` increments on each cycle with `pause_mem_o` = 1.
  - Both counters wrap at 2^32 and reset to 0.
- When undefined: both counter outputs are constant 0 and no counter flops are synthesized.

## Test plan
- Slot 0 load at 0x1000, slot 1 non-memory; `dc_addr_ok_i` immediate, `dc_data_ok_i` +1 with 0xDEADBEEF -> `slot_rdata_o[0]` = 0xDEADBEEF, `slot_done_o` = 01, `pause_mem_o` high for 3 cycles.
- Slot 0 store 0x2000 (strobe 0011), slot 1 load 0x2004 -> two requests in order, first with `dc_we_o` = 1; `slot_done_o` = 11 after 5 cycles.
- Slot 0 with exception, both slots memory ops -> no `dc_req_o`, `pause_mem_o` = 0.
- `dc_addr_ok_i` withheld for 4 cycles -> `dc_req_o` and payload held stable; `pause_mem_o` stays 1.
- `flush_i` in WAIT0, `dc_data_ok_i` 2 cycles later -> DRAIN swallows the response; slot 1 never requested; `slot_done_o` = 00.
- With `DCACHE_SCHED_PERF_EN` defined, run the two-access case -> `perf_req_cnt_o` = 2, `perf_stall_cnt_o` = 5.
